// File: rtl/alu_pkg.sv
// Opcode codes and sequencer state encoding shared by the sequencer and the external ALU.
package alu_pkg;

   localparam int unsigned OP_W = 6;

   localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
   localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
   localparam logic [OP_W-1:0] OP_AND = 6'b100100;
   localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
   localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
   localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
   localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
   localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

   typedef enum logic [2:0] {
      WAIT_A  = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      EXEC    = 3'd3,
      SEND    = 3'd4,
      WAIT_TX = 3'd5
   } seq_state_e;

   function automatic logic is_valid_op(input logic [OP_W-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte watchdog: counts enabled clocks since the last clear, flags when TIMEOUT is reached.
module frame_timer #(
   parameter int unsigned TIMEOUT = 1000000
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] r_count;

   assign o_expired = i_enable && (r_count == CW'(TIMEOUT));

   // Holds at TIMEOUT once reached; the next accepted byte clears it.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && !o_expired) begin
         r_count <= r_count + CW'(1);
      end
   end

endmodule

// File: rtl/uart_alu_sequencer.sv
// Collects operand A, operand B and opcode bytes from a UART receiver, drives an external ALU
// and hands the result byte to the UART transmitter.
module uart_alu_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned SIZ     = 8,
   parameter int unsigned NB_OP   = 6,
   parameter int unsigned TIMEOUT = 1000000
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_rx_done,
   input  logic [SIZ-1:0]   i_rx_data,
   output logic [SIZ-1:0]   o_alu_a,
   output logic [SIZ-1:0]   o_alu_b,
   output logic [NB_OP-1:0] o_alu_op,
   input  logic [SIZ-1:0]   i_alu_result,
   output logic             o_tx_start,
   output logic [SIZ-1:0]   o_tx_data,
   input  logic             i_tx_done,
   output logic             o_busy,
   output logic             o_err,
   output logic             o_timeout,
   output logic             o_overrun
);

   seq_state_e r_state;
   seq_state_e w_state_next;

   logic [SIZ-1:0]   r_alu_a;
   logic [SIZ-1:0]   r_alu_b;
   logic [NB_OP-1:0] r_alu_op;
   logic [SIZ-1:0]   r_tx_data;
   logic             r_err;
   logic             r_timeout;
   logic             r_overrun;

   logic w_err_d;
   logic w_timeout_d;
   logic w_overrun_d;
   logic w_in_frame;
   logic w_timer_en;
   logic w_expired;
   logic w_op_ok;

   // Bits above the opcode field must be clear for the byte to count as an opcode.
   assign w_op_ok = ((i_rx_data >> NB_OP) == '0) && is_valid_op(OP_W'(i_rx_data[NB_OP-1:0]));

   assign w_in_frame = (r_state == WAIT_A) || (r_state == WAIT_B) || (r_state == WAIT_OP);
   assign w_timer_en = (r_state == WAIT_B) || (r_state == WAIT_OP);

   frame_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_frame_timer (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_clear   (i_rx_done && w_in_frame),
      .i_enable  (w_timer_en),
      .o_expired (w_expired)
   );

   always_comb begin
      w_state_next = r_state;
      w_err_d      = 1'b0;
      w_timeout_d  = 1'b0;
      w_overrun_d  = 1'b0;
      case (r_state)
         WAIT_A: begin
            if (i_rx_done) w_state_next = WAIT_B;
         end
         WAIT_B: begin
            if (i_rx_done) begin
               w_state_next = WAIT_OP;
            end else if (w_expired) begin
               w_state_next = WAIT_A;
               w_timeout_d  = 1'b1;
            end
         end
         WAIT_OP: begin
            if (i_rx_done) begin
               if (w_op_ok) begin
                  w_state_next = EXEC;
               end else begin
                  w_state_next = WAIT_A;
                  w_err_d      = 1'b1;
               end
            end else if (w_expired) begin
               w_state_next = WAIT_A;
               w_timeout_d  = 1'b1;
            end
         end
         EXEC: begin
            w_state_next = SEND;
            w_overrun_d  = i_rx_done;
         end
         SEND: begin
            w_state_next = WAIT_TX;
            w_overrun_d  = i_rx_done;
         end
         WAIT_TX: begin
            if (i_tx_done) w_state_next = WAIT_A;
            w_overrun_d = i_rx_done;
         end
         default: w_state_next = WAIT_A;
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= WAIT_A;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_alu_a   <= '0;
         r_alu_b   <= '0;
         r_alu_op  <= '0;
         r_tx_data <= '0;
         r_err     <= 1'b0;
         r_timeout <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_err     <= w_err_d;
         r_timeout <= w_timeout_d;
         r_overrun <= w_overrun_d;
         if (i_rx_done && (r_state == WAIT_A)) r_alu_a <= i_rx_data;
         if (i_rx_done && (r_state == WAIT_B)) r_alu_b <= i_rx_data;
         if (i_rx_done && (r_state == WAIT_OP) && w_op_ok) r_alu_op <= i_rx_data[NB_OP-1:0];
         if (r_state == EXEC) r_tx_data <= i_alu_result;
      end
   end

   assign o_alu_a    = r_alu_a;
   assign o_alu_b    = r_alu_b;
   assign o_alu_op   = r_alu_op;
   assign o_tx_data  = r_tx_data;
   assign o_tx_start = (r_state == SEND);
   assign o_busy     = (r_state != WAIT_A);
   assign o_err      = r_err;
   assign o_timeout  = r_timeout;
   assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Directed bench for uart_alu_sequencer with a reference ALU and an event scoreboard.
module tb_uart_alu_sequencer;

   localparam int T = 20;

   localparam int K_TX      = 0;
   localparam int K_ERR     = 1;
   localparam int K_TIMEOUT = 2;
   localparam int K_OVERRUN = 3;

   typedef struct {
      int         kind;
      logic [7:0] data;
      int         cyc;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_done;
   logic [7:0] rx_data;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [5:0] alu_op;
   logic [7:0] alu_res;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_done;
   logic       busy;
   logic       err;
   logic       timeout;
   logic       overrun;

   int  n_tests = 0;
   int  n_fail  = 0;
   int  cyc     = 0;
   int  last_acc;
   ev_t sb[$];

   uart_alu_sequencer #(
      .SIZ     (8),
      .NB_OP   (6),
      .TIMEOUT (T)
   ) dut (
      .i_clock      (clk),
      .i_reset      (rst),
      .i_rx_done    (rx_done),
      .i_rx_data    (rx_data),
      .o_alu_a      (alu_a),
      .o_alu_b      (alu_b),
      .o_alu_op     (alu_op),
      .i_alu_result (alu_res),
      .o_tx_start   (tx_start),
      .o_tx_data    (tx_data),
      .i_tx_done    (tx_done),
      .o_busy       (busy),
      .o_err        (err),
      .o_timeout    (timeout),
      .o_overrun    (overrun)
   );

   // Reference combinational ALU
   always_comb begin
      alu_res = 8'h00;
      case (alu_op)
         6'b100000: alu_res = alu_a + alu_b;
         6'b100010: alu_res = alu_a - alu_b;
         6'b100100: alu_res = alu_a & alu_b;
         6'b100101: alu_res = alu_a | alu_b;
         6'b100110: alu_res = alu_a ^ alu_b;
         6'b100111: alu_res = ~(alu_a | alu_b);
         6'b000011: alu_res = 8'($signed(alu_a) >>> alu_b);
         6'b000010: alu_res = alu_a >> alu_b;
         default:   alu_res = 8'h00;
      endcase
   end

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic ok, input int act, input int exp);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic mon_event(input int kind, input logic [7:0] data);
      ev_t e;
      chk("event expected", sb.size() > 0, sb.size(), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("event kind", e.kind == kind, kind, e.kind);
         chk("event cycle", e.cyc == cyc, cyc, e.cyc);
         if (kind == K_TX) chk("tx data", e.data == data, data, e.data);
      end
   endtask

   always @(negedge clk) begin
      if (tx_start) mon_event(K_TX, tx_data);
      if (err)      mon_event(K_ERR, 8'h00);
      if (timeout)  mon_event(K_TIMEOUT, 8'h00);
      if (overrun)  mon_event(K_OVERRUN, 8'h00);
   end

   // Called #1 after a rising edge; returns #1 after the edge that sampled the byte.
   task automatic send_byte(input logic [7:0] b);
      rx_done = 1'b1;
      rx_data = b;
      @(posedge clk);
      #1;
      rx_done  = 1'b0;
      last_acc = cyc;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_tx_done();
      tx_done = 1'b1;
      @(posedge clk);
      #1;
      tx_done = 1'b0;
   endtask

   task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input logic [7:0] res);
      send_byte(a);
      send_byte(b);
      send_byte(op);
      sb.push_back('{K_TX, res, last_acc + 1});
      idle(3);
      chk("busy in WAIT_TX", busy == 1'b1, busy, 1);
      chk("tx data held", tx_data == res, tx_data, res);
      pulse_tx_done();
      chk("idle after tx_done", busy == 1'b0, busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst     = 1'b1;
      rx_done = 1'b0;
      rx_data = 8'h00;
      tx_done = 1'b0;
      idle(3);
      chk("reset operands", {alu_a, alu_b, alu_op, tx_data} == '0, {alu_a, alu_b}, 0);
      chk("reset flags", {tx_start, busy, err, timeout, overrun} == '0,
          {tx_start, busy, err, timeout, overrun}, 0);
      rst = 1'b0;
      idle(2);

      // ADD, SUB, SRA and the remaining logic/shift ops
      do_frame(8'h05, 8'h03, 8'h20, 8'h08);
      do_frame(8'h03, 8'h05, 8'h22, 8'hFE);
      do_frame(8'hF0, 8'h02, 8'h03, 8'hFC);

      // Invalid opcode: error pulse, opcode register untouched
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h3F);
      sb.push_back('{K_ERR, 8'h00, last_acc});
      idle(1);
      chk("idle after err", busy == 1'b0, busy, 0);
      chk("op kept after err", alu_op == 6'h03, alu_op, 6'h03);
      do_frame(8'h01, 8'h01, 8'h24, 8'h01);

      // Opcode field valid but upper bits set
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h60);
      sb.push_back('{K_ERR, 8'h00, last_acc});
      idle(1);
      chk("op kept after high bits", alu_op == 6'h24, alu_op, 6'h24);

      do_frame(8'h0F, 8'hFF, 8'h26, 8'hF0);
      do_frame(8'h0F, 8'hF0, 8'h27, 8'h00);
      do_frame(8'h80, 8'h03, 8'h02, 8'h10);

      // tx_done outside WAIT_TX is ignored
      send_byte(8'h0C);
      pulse_tx_done();
      chk("busy after stray tx_done", busy == 1'b1, busy, 1);
      send_byte(8'h03);
      send_byte(8'h25);
      sb.push_back('{K_TX, 8'h0F, last_acc + 1});
      idle(3);
      pulse_tx_done();

      // Timeout after T silent clocks
      send_byte(8'h07);
      sb.push_back('{K_TIMEOUT, 8'h00, last_acc + T + 1});
      idle(T + 2);
      chk("idle after timeout", busy == 1'b0, busy, 0);

      // Byte on the expiry cycle wins over the timeout
      send_byte(8'h07);
      idle(T);
      send_byte(8'h09);
      chk("byte on expiry accepted", alu_b == 8'h09, alu_b, 8'h09);
      send_byte(8'h25);
      sb.push_back('{K_TX, 8'h0F, last_acc + 1});
      idle(3);
      pulse_tx_done();

      // Overrun in WAIT_TX leaves registers unchanged
      send_byte(8'h05);
      send_byte(8'h03);
      send_byte(8'h20);
      sb.push_back('{K_TX, 8'h08, last_acc + 1});
      idle(3);
      send_byte(8'hAA);
      sb.push_back('{K_OVERRUN, 8'h00, last_acc});
      idle(1);
      chk("tx data after overrun", tx_data == 8'h08, tx_data, 8'h08);
      chk("operand A after overrun", alu_a == 8'h05, alu_a, 8'h05);
      chk("busy after overrun", busy == 1'b1, busy, 1);
      pulse_tx_done();

      // Reset in WAIT_OP
      send_byte(8'h01);
      send_byte(8'h02);
      rst = 1'b1;
      #1;
      chk("reset mid-frame regs", {alu_a, alu_b, alu_op, tx_data} == '0, {alu_a, alu_b}, 0);
      chk("reset mid-frame flags", {tx_start, busy, err, timeout, overrun} == '0,
          {tx_start, busy, err, timeout, overrun}, 0);
      idle(1);
      rst = 1'b0;
      idle(5);

      // Reset in EXEC: no tx_start may follow
      send_byte(8'h01);
      send_byte(8'h01);
      send_byte(8'h20);
      rst = 1'b1;
      #1;
      chk("reset in EXEC", {tx_start, busy} == 2'b00, {tx_start, busy}, 0);
      idle(1);
      rst = 1'b0;
      idle(6);

      chk("scoreboard drained", sb.size() == 0, sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_alu_sequencer.md
UART_ALU_SEQUENCER -- requirements
Module: uart_alu_sequencer

Interface
REQ-001 Parameter SIZ, default 8: data/operand width in bits, equal to the UART byte width.
REQ-002 Parameter NB_OP, default 6: ALU opcode width in bits, taken from the low bits of the opcode byte.
REQ-003 Parameter TIMEOUT, default 1000000: maximum number of clocks allowed between consecutive received bytes of one frame.
REQ-004 i_clock  in  1  single system clock; all state updates on its rising edge.
REQ-005 i_reset  in  1  reset, asynchronous, active-high.
REQ-006 i_rx_done  in  1  one-clock pulse from the UART receiver: a byte is valid on i_rx_data.
REQ-007 i_rx_data  in  SIZ  received byte.
REQ-008 o_alu_a, o_alu_b  out  SIZ each  registered operands driven to the combinational ALU.
REQ-009 o_alu_op  out  NB_OP  registered opcode driven to the ALU.
REQ-010 i_alu_result  in  SIZ  combinational ALU result.
REQ-011 o_tx_start  out  1  one-clock pulse requesting the UART transmitter to send o_tx_data.
REQ-012 o_tx_data  out  SIZ  registered result byte; stable from the o_tx_start pulse until i_tx_done.
REQ-013 i_tx_done  in  1  one-clock pulse from the transmitter at the end of its stop bit.
REQ-014 o_busy  out  1  high in every state except WAIT_A.
REQ-015 o_err, o_timeout, o_overrun  out  1 each  one-clock error pulses.

Function
REQ-016 The FSM SHALL have the states WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND and WAIT_TX.
REQ-017 In WAIT_A, i_rx_done SHALL latch the byte into o_alu_a, and the FSM SHALL go to WAIT_B.
REQ-018 In WAIT_B, i_rx_done SHALL latch the byte into o_alu_b, and the FSM SHALL go to WAIT_OP.
REQ-019 In WAIT_OP, i_rx_done SHALL check byte[NB_OP-1:0] against the valid set: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010.
REQ-020 A valid opcode SHALL be latched into o_alu_op, and the FSM SHALL go to EXEC.
REQ-021 An invalid opcode, or any set bits above NB_OP, SHALL pulse o_err for one clock, leave o_alu_op unchanged, and return the FSM to WAIT_A.
REQ-022 EXEC SHALL last exactly one clock and register i_alu_result into o_tx_data.
REQ-023 SEND SHALL last exactly one clock with o_tx_start=1, then go to WAIT_TX.
REQ-024 The latency from the opcode i_rx_done to the o_tx_start pulse SHALL be exactly 2 clocks.
REQ-025 WAIT_TX SHALL hold until i_tx_done, then return to WAIT_A.
REQ-026 An i_rx_done in EXEC, SEND or WAIT_TX SHALL be discarded, SHALL pulse o_overrun, and SHALL leave all registers unchanged.
REQ-027 A timeout counter (width clog2(TIMEOUT+1)) SHALL clear on every accepted byte and count only in WAIT_B and WAIT_OP.
REQ-028 When the counter reaches TIMEOUT, the block SHALL pulse o_timeout and return to WAIT_A.
REQ-029 If i_rx_done coincides with the timeout expiry, the byte SHALL be accepted and no timeout SHALL occur.
REQ-030 In WAIT_TX, i_tx_done is awaited indefinitely (no timeout).
REQ-031 An i_tx_done outside WAIT_TX SHALL be ignored.

Reset
REQ-032 While i_reset=1, the FSM SHALL be in WAIT_A; o_alu_a, o_alu_b, o_alu_op, o_tx_data and the counter SHALL be 0; and o_tx_start, o_busy, o_err, o_timeout and o_overrun SHALL be 0.
REQ-033 A reset asserted mid-frame or mid-transmission SHALL abandon the frame immediately, with no o_tx_start pulse afterwards.

Structure
REQ-034 The opcode localparams (the eight codes) and the state encoding SHALL reside in a shared package alu_pkg, which the ALU also uses.
REQ-035 The timeout counter SHALL be a sub-module frame_timer (inputs clear and enable; output expired).
REQ-036 The block SHALL contain no arithmetic on data; the ALU stays external.

Verification
REQ-037 Bytes 0x05, 0x03, 0x20 (ADD) -> o_tx_start two clocks after the third i_rx_done with o_tx_data=0x08; after i_tx_done, o_busy=0.
REQ-038 Bytes 0x03, 0x05, 0x22 (SUB) -> o_tx_data=0xFE; then 0xF0, 0x02, 0x03 (SRA) -> o_tx_data=0xFC.
REQ-039 Bytes 0x01, 0x02, 0x3F -> o_err pulse, no o_tx_start, state WAIT_A; the next frame 0x01, 0x01, 0x24 -> 0x01.
REQ-040 Byte 0x07 then silence for TIMEOUT clocks -> o_timeout pulse, o_busy=0; a byte arriving on the expiry cycle is accepted instead.
REQ-041 An i_rx_done of 0xAA during WAIT_TX -> o_overrun pulse and o_tx_data unchanged; i_reset asserted in WAIT_OP -> all outputs 0, no subsequent o_tx_start.
